// File: rtl/vrf_accesser_pkg.sv
// Shared types for the banked VRF accesser: address layout, data/strobe widths, read port ids.
package vrf_accesser_pkg;

  localparam int NrBank    = 4;
  localparam int BankSelW  = $clog2(NrBank);
  localparam int BankAddrW = 6;
  localparam int DataW     = 32;
  localparam int StrbW     = DataW / 8;

  typedef logic [BankAddrW-1:0] bank_addr_t;
  typedef logic [BankSelW-1:0]  bank_sel_t;
  typedef logic [DataW-1:0]     vrf_data_t;
  typedef logic [StrbW-1:0]     vrf_strb_t;

  // Bank select sits in the low bits so consecutive words interleave across banks.
  typedef struct packed {
    bank_addr_t addr;
    bank_sel_t  bank;
  } vrf_addr_t;

  localparam int VrfAddrWidth = $bits(vrf_addr_t);

  typedef enum logic [1:0] {OpVs1, OpVs2, OpVd} rd_port_e;

endpackage

// File: rtl/vrf_accesser_bank_arbiter.sv
// One bank's grant logic: starved reads, then the write port, then ordinary reads,
// with a round-robin pointer shared by both read priority levels.
module vrf_accesser_bank_arbiter #(
  parameter int NrReadPort = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NrReadPort-1:0] rd_req_i,
  input  logic [NrReadPort-1:0] starved_i,
  input  logic                  wr_req_i,
  output logic [NrReadPort-1:0] rd_gnt_o,
  output logic                  wr_gnt_o
);

  localparam int PtrW = (NrReadPort > 1) ? $clog2(NrReadPort) : 1;

  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [NrReadPort-1:0] hi_req, lo_req;

  // Walk from the farthest offset down so the nearest requester to ptr wins.
  function automatic logic [NrReadPort-1:0] rr_pick(input logic [NrReadPort-1:0] req,
                                                    input logic [PtrW-1:0]       ptr);
    logic [NrReadPort-1:0] g;
    g = '0;
    for (int i = NrReadPort - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(ptr) + i) % NrReadPort;
      if (req[idx]) begin
        g      = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb begin
    hi_req   = rd_req_i & starved_i;
    lo_req   = rd_req_i & ~starved_i;
    rd_gnt_o = rr_pick(hi_req, ptr_q);
    wr_gnt_o = 1'b0;
    ptr_d    = ptr_q;
    if (rd_gnt_o == '0) begin
      wr_gnt_o = wr_req_i;
      if (!wr_req_i) rd_gnt_o = rr_pick(lo_req, ptr_q);
    end
    for (int p = 0; p < NrReadPort; p++)
      if (rd_gnt_o[p]) ptr_d = PtrW'((p + 1) % NrReadPort);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vrf_accesser.sv
// Per-lane VRF bank arbiter: routes operand reads and writeback onto the banked SRAM,
// tracks read starvation and returns read data one cycle after the grant.
module vrf_accesser
  import vrf_accesser_pkg::*;
#(
  parameter int NrReadPort   = 3,
  parameter int MaxReadStall = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic      [NrReadPort-1:0]   rd_valid_i,
  output logic      [NrReadPort-1:0]   rd_ready_o,
  input  vrf_addr_t [NrReadPort-1:0]   rd_addr_i,
  output logic      [NrReadPort-1:0]   rd_resp_valid_o,
  output vrf_data_t [NrReadPort-1:0]   rd_resp_data_o,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  vrf_addr_t                    wr_addr_i,
  input  vrf_data_t                    wr_data_i,
  input  vrf_strb_t                    wr_strb_i,
  output logic       [NrBank-1:0]      bank_req_o,
  output bank_addr_t [NrBank-1:0]      bank_addr_o,
  output logic       [NrBank-1:0]      bank_wen_o,
  output vrf_data_t  [NrBank-1:0]      bank_wdata_o,
  output vrf_strb_t  [NrBank-1:0]      bank_wstrb_o,
  input  vrf_data_t  [NrBank-1:0]      bank_rdata_i
);

  logic [NrReadPort-1:0][3:0]         stall_cnt;
  logic [NrReadPort-1:0]              starved;
  logic [NrBank-1:0][NrReadPort-1:0]  bank_rd_req, bank_rd_gnt;
  logic [NrBank-1:0]                  bank_wr_req, bank_wr_gnt;
  logic [NrReadPort-1:0]              vld_pipe;
  bank_sel_t [NrReadPort-1:0]         bank_q;

  always_comb begin
    starved     = '0;
    bank_rd_req = '0;
    bank_wr_req = '0;
    for (int p = 0; p < NrReadPort; p++)
      starved[p] = stall_cnt[p] >= 4'(MaxReadStall);
    for (int b = 0; b < NrBank; b++) begin
      for (int p = 0; p < NrReadPort; p++)
        bank_rd_req[b][p] = rd_valid_i[p] && (rd_addr_i[p].bank == bank_sel_t'(b));
      bank_wr_req[b] = wr_valid_i && (wr_addr_i.bank == bank_sel_t'(b));
    end
  end

  for (genvar b = 0; b < NrBank; b++) begin : g_bank
    vrf_accesser_bank_arbiter #(.NrReadPort(NrReadPort)) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .rd_req_i  (bank_rd_req[b]),
      .starved_i (starved),
      .wr_req_i  (bank_wr_req[b]),
      .rd_gnt_o  (bank_rd_gnt[b]),
      .wr_gnt_o  (bank_wr_gnt[b])
    );
  end

  always_comb begin
    rd_ready_o   = '0;
    wr_ready_o   = 1'b0;
    bank_req_o   = '0;
    bank_addr_o  = '0;
    bank_wen_o   = '0;
    bank_wdata_o = '0;
    bank_wstrb_o = '0;
    if (!rst_i) begin
      for (int b = 0; b < NrBank; b++) begin
        if (bank_wr_gnt[b]) begin
          wr_ready_o      = 1'b1;
          bank_req_o[b]   = 1'b1;
          bank_wen_o[b]   = 1'b1;
          bank_addr_o[b]  = wr_addr_i.addr;
          bank_wdata_o[b] = wr_data_i;
          bank_wstrb_o[b] = wr_strb_i;
        end
        for (int p = 0; p < NrReadPort; p++) begin
          if (bank_rd_gnt[b][p]) begin
            rd_ready_o[p]  = 1'b1;
            bank_req_o[b]  = 1'b1;
            bank_addr_o[b] = rd_addr_i[p].addr;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      vld_pipe  <= '0;
      bank_q    <= '0;
    end else begin
      for (int p = 0; p < NrReadPort; p++) begin
        if (rd_valid_i[p] && !rd_ready_o[p])
          stall_cnt[p] <= (stall_cnt[p] == 4'hf) ? 4'hf : stall_cnt[p] + 4'd1;
        else
          stall_cnt[p] <= '0;
        bank_q[p] <= rd_addr_i[p].bank;
      end
      vld_pipe <= rd_ready_o;
    end
  end

  // Gating with rst_i drops a response already in flight when reset arrives.
  always_comb begin
    rd_resp_valid_o = '0;
    rd_resp_data_o  = '0;
    for (int p = 0; p < NrReadPort; p++) begin
      rd_resp_valid_o[p] = vld_pipe[p] && !rst_i;
      if (rd_resp_valid_o[p]) rd_resp_data_o[p] = bank_rdata_i[bank_q[p]];
    end
  end

endmodule

// File: tb/tb_vrf_accesser.sv
// Directed bench for vrf_accesser: a strobed SRAM model behind the bank ports and a
// per-port scoreboard that matches read responses on data and arrival cycle.
module tb_vrf_accesser;
  import vrf_accesser_pkg::*;

  localparam int NP = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic      [NP-1:0]        rd_valid, rd_ready, resp_valid;
  vrf_addr_t [NP-1:0]        rd_addr;
  vrf_data_t [NP-1:0]        resp_data;
  logic                      wr_valid, wr_ready;
  vrf_addr_t                 wr_addr;
  vrf_data_t                 wr_data;
  vrf_strb_t                 wr_strb;
  logic       [NrBank-1:0]   bank_req, bank_wen;
  bank_addr_t [NrBank-1:0]   bank_addr;
  vrf_data_t  [NrBank-1:0]   bank_wdata, bank_rdata;
  vrf_strb_t  [NrBank-1:0]   bank_wstrb;

  vrf_accesser #(.NrReadPort(NP), .MaxReadStall(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr_i(rd_addr),
    .rd_resp_valid_o(resp_valid), .rd_resp_data_o(resp_data),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_strb_i(wr_strb),
    .bank_req_o(bank_req), .bank_addr_o(bank_addr), .bank_wen_o(bank_wen),
    .bank_wdata_o(bank_wdata), .bank_wstrb_o(bank_wstrb), .bank_rdata_i(bank_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: word contents start as B0bb_aaaa (bank, word address)
  vrf_data_t mem [NrBank][1 << BankAddrW];

  initial begin
    for (int b = 0; b < NrBank; b++)
      for (int a = 0; a < (1 << BankAddrW); a++)
        mem[b][a] <= 32'hB000_0000 | (32'(b) << 16) | 32'(a);
  end

  always @(posedge clk) begin
    for (int b = 0; b < NrBank; b++) begin
      if (bank_req[b]) begin
        if (bank_wen[b]) begin
          for (int k = 0; k < StrbW; k++)
            if (bank_wstrb[b][k]) mem[b][bank_addr[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
        end else begin
          bank_rdata[b] <= mem[b][bank_addr[b]];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    vrf_data_t data;
    int        due;
  } exp_t;

  exp_t exp_q [NP][$];

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int p = 0; p < NP; p++) begin
      if (resp_valid[p]) begin
        if (exp_q[p].size() == 0) begin
          chk($sformatf("resp_unexpected_p%0d", p), resp_valid[p], 1'b0);
        end else begin
          e = exp_q[p].pop_front();
          chk($sformatf("resp_data_p%0d", p), resp_data[p], e.data);
          chk($sformatf("resp_cycle_p%0d", p), cyc, e.due);
        end
      end else begin
        if (resp_data[p] !== '0) chk($sformatf("resp_idle_data_p%0d", p), resp_data[p], '0);
        if (exp_q[p].size() != 0 && exp_q[p][0].due <= cyc) begin
          e = exp_q[p].pop_front();
          chk($sformatf("resp_missing_p%0d", p), resp_valid[p], 1'b1);
        end
      end
    end
  end

  // Checks handshakes at the negedge and queues the responses the grants should produce.
  task automatic cycle_chk(input string tag, input logic [NP-1:0] exp_rd, input logic exp_wr,
                           input logic [NP-1:0] push, input vrf_data_t [NP-1:0] d);
    @(negedge clk);
    chk({tag, ".rd_ready"}, rd_ready, exp_rd);
    chk({tag, ".wr_ready"}, wr_ready, exp_wr);
    for (int p = 0; p < NP; p++)
      if (push[p]) exp_q[p].push_back('{data: d[p], due: cyc + 1});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rd_valid = '0; rd_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset.bank_req", bank_req, '0);
    chk("reset.resp_valid", resp_valid, '0);
    chk("reset.stall_cnt", dut.stall_cnt, '0);
    tick();

    // 1: three ports, three banks, all in one cycle
    rd_valid   = 3'b111;
    rd_addr[0] = '{addr: 6'd5, bank: 2'd0};
    rd_addr[1] = '{addr: 6'd6, bank: 2'd1};
    rd_addr[2] = '{addr: 6'd7, bank: 2'd2};
    cycle_chk("t1", 3'b111, 1'b0, 3'b111, {32'hB002_0007, 32'hB001_0006, 32'hB000_0005});
    chk("t1.bank_req", bank_req, 4'b0111);
    chk("t1.bank_wen", bank_wen, 4'b0000);
    chk("t1.bank_wdata", bank_wdata, '0);
    chk("t1.bank_addr", bank_addr, {6'd0, 6'd7, 6'd6, 6'd5});
    tick();
    rd_valid = '0;

    // 2: ports 0 and 1 contend for bank 3, pointer starts at 0
    rd_valid   = 3'b011;
    rd_addr[0] = '{addr: 6'd1, bank: 2'd3};
    rd_addr[1] = '{addr: 6'd2, bank: 2'd3};
    for (int i = 0; i < 4; i++) begin
      cycle_chk($sformatf("t2.%0d", i), (i % 2 == 0) ? 3'b001 : 3'b010, 1'b0,
                (i % 2 == 0) ? 3'b001 : 3'b010, {32'h0, 32'hB003_0002, 32'hB003_0001});
      tick();
    end
    rd_valid = '0;

    // 3: write hogs bank 2 until port 1 starves
    wr_valid   = 1'b1;
    wr_addr    = '{addr: 6'd20, bank: 2'd2};
    wr_data    = 32'hCAFE_0000;
    wr_strb    = 4'hF;
    rd_valid   = 3'b010;
    rd_addr[1] = '{addr: 6'd7, bank: 2'd2};
    for (int i = 0; i < 4; i++) begin
      cycle_chk($sformatf("t3.deny%0d", i), 3'b000, 1'b1, 3'b000, '0);
      tick();
    end
    cycle_chk("t3.starved", 3'b010, 1'b0, 3'b010, {32'h0, 32'hB002_0007, 32'h0});
    tick();
    rd_valid = '0;
    cycle_chk("t3.wr_resume", 3'b000, 1'b1, 3'b000, '0);
    tick();

    // 4: same-address read and write, write wins
    wr_addr    = '{addr: 6'd9, bank: 2'd0};
    wr_data    = 32'h0000_00A5;
    wr_strb    = 4'hF;
    rd_valid   = 3'b001;
    rd_addr[0] = '{addr: 6'd9, bank: 2'd0};
    cycle_chk("t4.wr", 3'b000, 1'b1, 3'b000, '0);
    chk("t4.wen", bank_wen[0], 1'b1);
    chk("t4.wdata", bank_wdata[0], 32'h0000_00A5);
    chk("t4.waddr", bank_addr[0], 6'd9);
    tick();
    wr_valid = 1'b0;
    cycle_chk("t4.rd", 3'b001, 1'b0, 3'b001, {32'h0, 32'h0, 32'h0000_00A5});
    chk("t4.rd_wen", bank_wen[0], 1'b0);
    chk("t4.rd_wdata", bank_wdata[0], 32'h0);
    chk("t4.rd_wstrb", bank_wstrb[0], 4'h0);
    tick();
    rd_valid = '0;

    // 5: partial strobe write over 0x0000FFFF
    wr_valid = 1'b1;
    wr_addr  = '{addr: 6'd3, bank: 2'd1};
    wr_data  = 32'h0000_FFFF;
    wr_strb  = 4'hF;
    cycle_chk("t5.wr_full", 3'b000, 1'b1, 3'b000, '0);
    tick();
    wr_data = 32'h1234_5678;
    wr_strb = 4'h1;
    cycle_chk("t5.wr_byte0", 3'b000, 1'b1, 3'b000, '0);
    chk("t5.wstrb", bank_wstrb[1], 4'h1);
    tick();
    wr_valid   = 1'b0;
    rd_valid   = 3'b100;
    rd_addr[2] = '{addr: 6'd3, bank: 2'd1};
    cycle_chk("t5.rd", 3'b100, 1'b0, 3'b100, {32'h0000_FF78, 32'h0, 32'h0});
    tick();
    rd_valid = '0;

    // 6: reset right after a grant; bank 3 pointer is at 2 so port 2 wins, port 0 stalls
    rd_valid   = 3'b101;
    rd_addr[0] = '{addr: 6'd1, bank: 2'd3};
    rd_addr[2] = '{addr: 6'd4, bank: 2'd3};
    cycle_chk("t6.grant", 3'b100, 1'b0, 3'b000, '0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6.rst_resp_valid", resp_valid, '0);
    chk("t6.rst_rd_ready", rd_ready, '0);
    chk("t6.rst_bank_req", bank_req, '0);
    chk("t6.stall_before", dut.stall_cnt[0], 4'd1);
    tick();
    rst      = 1'b0;
    rd_valid = '0;
    @(negedge clk);
    chk("t6.post_resp_valid", resp_valid, '0);
    chk("t6.post_stall_cnt", dut.stall_cnt, '0);
    chk("t6.post_bank_req", bank_req, '0);
    tick();

    repeat (2) tick();
    for (int p = 0; p < NP; p++)
      chk($sformatf("drain_p%0d", p), exp_q[p].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vrf_accesser.md
Name: vrf_accesser

Overview:
Per-lane arbiter that sits directly upstream of the banked VRF SRAM array and drives its per-bank request/address/write-enable/data/strobe inputs. Collects read requests from the operand-fetch ports and one writeback port, resolves bank conflicts each cycle, and returns read data to the requesting port. Bank read latency is fixed at one cycle.

Parameters:
NrReadPort, 3, number of operand read requesters (vs1, vs2, vd/mask).
MaxReadStall, 4, consecutive denied cycles after which a read port outranks the write port; range 1..15.
(NrBank, bank_addr_t, vrf_data_t, vrf_strb_t come from core_pkg.)

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous reset, active-high.
rd_valid_i  in  NrReadPort  read request valid per port.
rd_ready_o  out  NrReadPort  read request granted this cycle.
rd_addr_i  in  NrReadPort x VrfAddrWidth  vrf_addr_t per port: bank select in the low log2(NrBank) bits, bank_addr_t in the upper bits.
rd_resp_valid_o  out  NrReadPort  read data valid, one cycle after the grant.
rd_resp_data_o  out  NrReadPort x vrf_data_t  read data.
wr_valid_i  in  1  writeback request valid.
wr_ready_o  out  1  write granted this cycle.
wr_addr_i  in  VrfAddrWidth  write address, same vrf_addr_t format as the read addresses.
wr_data_i  in  vrf_data_t  write data.
wr_strb_i  in  vrf_strb_t  byte strobes.
bank_req_o  out  NrBank  per-bank access enable.
bank_addr_o  out  NrBank x bank_addr_t  per-bank word address.
bank_wen_o  out  NrBank  per-bank write enable.
bank_wdata_o  out  NrBank x vrf_data_t  per-bank write data.
bank_wstrb_o  out  NrBank x vrf_strb_t  per-bank strobes.
bank_rdata_i  in  NrBank x vrf_data_t  bank read data, valid one cycle after bank_req_o with bank_wen_o=0.

Behaviour:
- Handshakes: rd/wr are valid/ready. ready is combinational from the current valids and state. A request holds valid and address stable until ready. There is no response backpressure: upstream reserves queue space before raising rd_valid_i.
- Per-bank arbitration, every cycle, among the requesters that target that bank:
  - Priority 1: read ports whose stall counter is >= MaxReadStall, resolved round-robin among themselves.
  - Priority 2: the write port.
  - Priority 3: the remaining read ports, round-robin.
- Round-robin: one pointer per bank. After a read grant on a bank, that bank's pointer moves to (granted port + 1) mod NrReadPort. A write grant leaves the pointer unchanged.
- Grant limits: at most one grant per bank per cycle. Each port targets exactly one bank, so each port gets at most one grant per cycle.
- Bank outputs: bank_req_o[b]=1 only when bank b has a grant.
  - Write grant: bank_wen_o=1; addr, wdata and wstrb come from the write port.
  - Read grant: bank_wen_o=0; bank_wdata_o and bank_wstrb_o are 0.
  - Idle bank: all bank outputs are 0.
- Stall counters: 4 bits per read port.
  - Increment, saturating at 15, when rd_valid_i=1 and rd_ready_o=0.
  - Clear on grant or when rd_valid_i=0.
- Response pipeline: one register stage per read port holding a valid bit and the granted bank index. In cycle N+1, rd_resp_valid_o[p]=1 and rd_resp_data_o[p]=bank_rdata_i[bank]. The data output is 0 whenever its valid is low.
- Same-address read and write in one cycle: only one is granted, with no forwarding.
  - Write wins: the read stalls and later returns the new data.
  - Read wins (starved read): the read returns the old data, and the write stalls one cycle.
- Reset: when rst_i=1 at a clock edge, all pointers, stall counters and response valids clear.
  - While rst_i=1, all ready and bank outputs are forced to 0.
  - An in-flight response is dropped: rd_resp_valid_o=0 in the cycle after reset.
- Throughput: up to NrBank accesses per cycle when there are no conflicts.

Decomposition:
- core_pkg additions: VrfAddrWidth; vrf_addr_t (packed struct of bank_addr_t and a log2(NrBank)-bit bank index); rd_port_e enum (OpVs1, OpVs2, OpVd).
- Natural sub-module: vrf_bank_arbiter, instantiated once per bank. It owns the round-robin pointer and the three-level priority logic.
- Stall counters and the response pipeline stay in the top level.

Test Plan:
1. Ports 0/1/2 read banks 0/1/2, addresses 5/6/7, with no write → all three ready in the same cycle; next cycle each rd_resp_data_o equals that bank's word.
2. Ports 0 and 1 hold requests to bank 3 for 4 cycles, rr pointer starts at 0 → grants alternate 0,1,0,1; each response arrives exactly 1 cycle after its grant.
3. Continuous writes to bank 2 while port 1 holds a read of bank 2 → port 1 is denied 4 cycles, granted in cycle 5, and the write is stalled in that cycle.
4. Write 0xA5 with full strobe to bank 0 addr 9, and a port 0 read of bank 0 addr 9 in the same cycle → write wins; the read is granted the next cycle and returns 0xA5.
5. Write with wr_strb_i=0x01 over an existing 0xFFFF word → the read-back shows only byte 0 changed.
6. Assert rst_i the cycle after a read grant → rd_resp_valid_o=0 the next cycle, all bank_req_o=0, and the stall counters read back as 0.
